// File: rtl/logic_unit_pkg.sv
// Shared types and the bitwise op evaluator used by the arbiter datapath and its bench model.
package logic_unit_pkg;

  // Widest operand eval_op handles; callers zero-extend in and truncate the result back.
  localparam int LU_MAX_WIDTH = 256;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_ANDN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [LU_MAX_WIDTH-1:0] eval_op(
    input logic [LU_MAX_WIDTH-1:0] a,
    input logic [LU_MAX_WIDTH-1:0] b,
    input op_e                     op
  );
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after i_last_grant, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx,
  output logic                       o_any
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    // Walk from the farthest offset to the nearest so the closest requester overwrites last.
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = IDW'((int'(i_last_grant) + off) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_gnt     = NUM_REQ'(1) << w_idx;
        o_gnt_idx = w_idx;
        o_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared bitwise logic unit: grant in IDLE, compute in EXEC, hold response in RESP.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_b,
  input  logic [NUM_REQ-1:0][1:0]          req_op,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [WIDTH-1:0]                 rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_op;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_last_grant;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt),
    .o_gnt_idx    (w_gnt_idx),
    .o_any        (w_any)
  );

  // Grants are only offered in IDLE; EXEC and RESP never accept a new request.
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_AND;
      r_id         <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= req_a[w_gnt_idx];
            r_b     <= req_b[w_gnt_idx];
            r_op    <= op_e'(req_op[w_gnt_idx]);
            r_id    <= w_gnt_idx;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= WIDTH'(eval_op(LU_MAX_WIDTH'(r_a), LU_MAX_WIDTH'(r_b), r_op));
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          // Priority rotates only once the consumer has taken the result.
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            r_last_grant <= rsp_id;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and table-driven bench for logic_unit_arbiter with a round-robin scoreboard.
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  localparam int NR = 4;
  localparam int W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0]           req_ready;
  logic [NR-1:0][W-1:0]    req_a;
  logic [NR-1:0][W-1:0]    req_b;
  logic [NR-1:0][1:0]      req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [W-1:0]            rsp_data;
  logic [1:0]              rsp_id;

  int n_total = 0;
  int n_bad   = 0;
  int m_last;

  logic [NR-1:0] t_valid;
  logic [W-1:0]  t_a [NR];
  logic [W-1:0]  t_b [NR];
  logic [1:0]    t_op[NR];

  typedef struct {
    int         id;
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[8];

  logic_unit_arbiter #(
    .NUM_REQ (NR),
    .WIDTH   (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = t_valid[i];
      req_a[i]     = t_a[i];
      req_b[i]     = t_b[i];
      req_op[i]    = t_op[i];
    end
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    t_valid[id] = 1'b1;
    t_op[id]    = op;
    t_a[id]     = a;
    t_b[id]     = b;
  endtask

  // Starts at a negedge in IDLE with stimulus applied; ends at the negedge back in IDLE.
  task automatic run_txn(input int exp_id, input logic [7:0] exp_data, input bit keep, input string name);
    check({name, "_grant"}, 32'(req_ready), 32'(1 << exp_id));
    @(negedge clk);
    if (!keep) begin
      t_valid[exp_id] = 1'b0;
      apply();
    end
    check({name, "_exec_rdy"}, 32'(req_ready), 32'd0);
    check({name, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({name, "_rsp_vld"}, 32'(rsp_valid), 32'd1);
    check({name, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
    check({name, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    check({name, "_resp_rdy"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({name, "_done_vld"}, 32'(rsp_valid), 32'd0);
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m, input int last);
    for (int off = 1; off <= NR; off++) begin
      int k;
      k = (last + off) % NR;
      if (m[k]) return k;
    end
    return 0;
  endfunction

  initial begin
    logic [LU_MAX_WIDTH-1:0] full;
    logic [7:0]              expd;
    logic [7:0]              cont_exp[NR];
    int                      e;

    vecs[0] = '{0, OP_AND,  8'hF0, 8'h3C, 8'h30, "v_and"};
    vecs[1] = '{0, OP_OR,   8'hF0, 8'h3C, 8'hFC, "v_or"};
    vecs[2] = '{0, OP_XOR,  8'hF0, 8'h3C, 8'hCC, "v_xor"};
    vecs[3] = '{0, OP_ANDN, 8'hF0, 8'h3C, 8'hC0, "v_andn"};
    vecs[4] = '{2, OP_XOR,  8'hAA, 8'hFF, 8'h55, "v_r2xor"};
    vecs[5] = '{3, OP_ANDN, 8'hFF, 8'h0F, 8'hF0, "v_r3andn"};
    vecs[6] = '{1, OP_OR,   8'h00, 8'h00, 8'h00, "v_r1zero"};
    vecs[7] = '{3, OP_AND,  8'hFF, 8'hFF, 8'hFF, "v_r3ones"};

    cont_exp[0] = 8'h01;  // 11 & 0F
    cont_exp[1] = 8'h2F;  // 22 | 0F
    cont_exp[2] = 8'h3C;  // 33 ^ 0F
    cont_exp[3] = 8'h40;  // 44 & ~0F

    t_valid   = '0;
    for (int i = 0; i < NR; i++) begin
      t_a[i]  = '0;
      t_b[i]  = '0;
      t_op[i] = '0;
    end
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n  = 1'b1;
    m_last = NR - 1;

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      apply();
      run_txn(vecs[i].id, vecs[i].exp, 1'b0, vecs[i].name);
      m_last = vecs[i].id;
    end

    // All requesters held valid: rotation 0,1,2,3,0 at one transaction per 3 cycles.
    for (int i = 0; i < NR; i++)
      set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h0F);
    apply();
    for (int k = 0; k < 5; k++)
      run_txn(k % NR, cont_exp[k % NR], 1'b1, "rot");
    m_last  = 0;
    t_valid = '0;
    apply();
    check("idle_no_req", 32'(req_ready), 32'd0);

    // Backpressure: response held for several cycles, no grant until handshake completes.
    rsp_ready = 1'b0;
    set_req(1, OP_OR,  8'h5A, 8'h0F);
    set_req(2, OP_XOR, 8'hC3, 8'hFF);
    apply();
    check("bp_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    t_valid[1] = 1'b0;
    apply();
    check("bp_exec_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      check("bp_hold_vld",  32'(rsp_valid), 32'd1);
      check("bp_hold_data", 32'(rsp_data),  32'h5F);
      check("bp_hold_id",   32'(rsp_id),    32'd1);
      check("bp_hold_rdy",  32'(req_ready), 32'd0);
      if (c < 5) @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_rdy", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_post_vld",  32'(rsp_valid), 32'd0);
    check("bp_post_data", 32'(rsp_data),  32'h5F);
    check("bp_post_id",   32'(rsp_id),    32'd1);
    run_txn(2, 8'h3C, 1'b0, "bp_next");
    m_last = 2;

    // Set last_grant to 1, then requests on 1 and 3: 3 wins, then 1.
    set_req(1, OP_AND, 8'hFF, 8'h81);
    apply();
    run_txn(1, 8'h81, 1'b0, "lg1");
    set_req(1, OP_OR,   8'h10, 8'h01);
    set_req(3, OP_ANDN, 8'hFF, 8'h0F);
    apply();
    run_txn(3, 8'hF0, 1'b0, "pair_r3");
    run_txn(1, 8'h11, 1'b0, "pair_r1");

    // Reset during EXEC drops the transaction.
    set_req(2, OP_XOR, 8'h0F, 8'hFF);
    apply();
    check("rx_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    t_valid = '0;
    apply();
    rst_n = 1'b0;
    @(negedge clk);
    check("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rx_rsp_data",  32'(rsp_data),  32'd0);
    check("rx_rsp_id",    32'(rsp_id),    32'd0);
    check("rx_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rx_dropped", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NR; i++)
      set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'h0F);
    apply();
    run_txn(0, 8'h01, 1'b0, "rx_first");
    m_last = 0;

    // Random traffic; ungranted requesters keep their request until served.
    for (int n = 0; n < 1000; n++) begin
      if (t_valid == '0) begin
        e = $urandom_range(0, NR - 1);
        set_req(e, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
      apply();
      e    = rr_pick(t_valid, m_last);
      full = eval_op(LU_MAX_WIDTH'(t_a[e]), LU_MAX_WIDTH'(t_b[e]), op_e'(t_op[e]));
      expd = full[7:0];
      run_txn(e, expd, 1'b0, "rnd");
      m_last = e;
      for (int i = 0; i < NR; i++) begin
        if (!t_valid[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one bitwise logic unit (AND / OR / XOR / AND-NOT over `WIDTH` bits) among `NUM_REQ` requesters. Requesters present operand pairs with a valid/ready handshake, and a round-robin arbiter grants one request at a time. The block computes the result into a register and returns it on a single response port tagged with the requester ID. It sits between the block's clients and the shared combinational logic datapath, and is the only driver of that datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, range 2..16.
- `WIDTH`, 8: operand and result width, minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester grant. At most one bit is high.
- `req_a` in `NUM_REQ`×`WIDTH`: operand A per requester.
- `req_b` in `NUM_REQ`×`WIDTH`: operand B per requester.
- `req_op` in `NUM_REQ`×2: op code per requester. 0 = AND, 1 = OR, 2 = XOR, 3 = ANDN (a & ~b).
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted by consumer.
- `rsp_data` out `WIDTH`: result.
- `rsp_id` out `$clog2(NUM_REQ)`: index of the requester that issued the result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready` is driven combinationally for the round-robin winner among asserted `req_valid`. The search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - A request handshake occurs when `req_valid[i] && req_ready[i]`. On that edge: capture a, b, op, id; go to EXEC.
  - With no `req_valid` asserted, stay in IDLE and keep `req_ready` at 0.
- EXEC:
  - `req_ready` is 0.
  - Compute the op on the captured operands and register it into `rsp_data`.
  - Set `rsp_valid`=1 and `rsp_id`=captured id, then go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - On the response handshake: `rsp_valid`←0, `last_grant`←id, go to IDLE.
  - `req_ready` stays 0 during RESP. No new grant is given in the handshake cycle.
- Round-robin fairness: a continuously requesting requester is granted within `NUM_REQ` transactions.
- `last_grant` advances only on completed responses.
- Requests not granted are not consumed. Requesters must hold `req_valid` and their operands until granted.
- `rsp_data` and `rsp_id` keep their last values while `rsp_valid`=0.
- Op codes are 2 bits, so there is no illegal code. The result width equals `WIDTH` and there is no carry.

## Timing
- Reset values:
  - state = IDLE
  - `req_ready` = 0, computed combinationally from IDLE with no valid
  - `rsp_valid` = 0
  - `rsp_data` = 0
  - `rsp_id` = 0
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority
- Latency: request handshake at edge T produces `rsp_valid` high after edge T+1, i.e. one cycle in EXEC.
- Best-case throughput: one transaction per 3 cycles (IDLE, EXEC, RESP with `rsp_ready` held high).
- Backpressure: the number of cycles in RESP is unbounded. No requests are granted meanwhile.
- Simultaneous `req_valid` on all lines: exactly one `req_ready`, chosen by rotating priority.
- Wrap-around: `last_grant`=`NUM_REQ`-1 makes requester 0 highest priority.
- Reset asserted in any state at an edge:
  - The next state is IDLE with reset values.
  - An in-flight transaction is dropped without a response.
  - The captured operands are don't-care.
- `req_valid` dropping in IDLE before a handshake is legal; no grant is taken.

## Structure
- `logic_unit_pkg` holds:
  - `op_e` enum: `OP_AND`, `OP_OR`, `OP_XOR`, `OP_ANDN`.
  - `state_e` enum: IDLE, EXEC, RESP.
  - The op-evaluation function `eval_op(a, b, op)`, shared with the datapath and the bench model.
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant, encoded index, and any-grant.
  - The top level owns the FSM, the operand/response registers and `last_grant`.

## Test plan
- Reset, then req0 with a=8'hF0, b=8'h3C, op=AND and `rsp_ready`=1 → `rsp_valid` two cycles after the grant, `rsp_data`=8'h30, `rsp_id`=0. Repeat with OR→8'hFC, XOR→8'hCC, ANDN→8'hC0.
- All four requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0, each transaction 3 cycles, `req_ready` one-hot.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_data`, `rsp_id` stable. No `req_ready` until the handshake, then IDLE, then the next grant.
- Requests on 1 and 3 only, `last_grant`=1 → req3 granted, then req1.
- `rst_n` low during EXEC → no response, all outputs at reset values next cycle. After release, req0 wins first.
- Random ops and operands across 1000 transactions checked against `eval_op`, with each `rsp_id` matching the granted requester.
